// File: rtl/keypad_event_fifo.sv
// Keypad event capture: synchronises and debounces a one-hot key vector,
// converts stable changes into press/release events and queues them in a
// small first-word-fall-through FIFO for a register block to drain.
module keypad_event_fifo #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int FIFO_DEPTH      = 8,
  parameter int ADDR_W          = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       keypad,
  output logic              ev_valid,
  output logic [7:0]        ev_data,
  input  logic              ev_pop,
  output logic [ADDR_W:0]   ev_count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_SWAP = 2'd2;

  logic [15:0]       sync1;
  logic [15:0]       s;
  logic [15:0]       cand;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       stable;
  logic [3:0]        pend;
  logic [1:0]        state;

  logic              cand_ok;
  logic              accept;
  logic              push_req;
  logic [7:0]        push_byte;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;

  // Position of the set bit in a one-hot vector (0 for an all-zero vector).
  function automatic logic [3:0] key_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = i[3:0];
    end
    return idx;
  endfunction

  // Two-flop synchroniser for the asynchronous scanner output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      // NOTE: registered state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      sync1 <= keypad;
      s     <= sync1;
    end
  end

  // Debounce: a candidate must be seen unchanged until the counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
    end else if (s != cand) begin
      cand <= s;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Zero or exactly one bit set; multi-key chords are never accepted.
  assign cand_ok = ((cand & (cand - 16'd1)) == 16'd0);
  assign accept  = (s == cand) && (cnt == CNT_MAX) && cand_ok &&
                   (cand != stable) && (state != ST_SWAP);

  // Key-state FSM: tracks the accepted key and schedules the swap press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      stable <= '0;
      pend   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            stable <= cand;
            state  <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (accept) begin
            stable <= cand;
            if (cand == 16'd0) begin
              state <= ST_IDLE;
            end else begin
              pend  <= key_index(cand);
              state <= ST_SWAP;
            end
          end
        end
        ST_SWAP: state <= ST_HELD;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Event generation: press on first key, release (then press) on changes.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    push_req  = 1'b0;
    push_byte = 8'h00;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          push_req  = 1'b1;
          push_byte = {1'b1, 3'b000, key_index(cand)};
        end
      end
      ST_HELD: begin
        if (accept) begin
          push_req  = 1'b1;
          push_byte = {1'b0, 3'b000, key_index(stable)};
        end
      end
      ST_SWAP: begin
        push_req  = 1'b1;
        push_byte = {1'b1, 3'b000, pend};
      end
      default: begin
        push_req  = 1'b0;
        push_byte = 8'h00;
      end
    endcase
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = ev_pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are meaningful, and ev_data is forced to 0 when empty.
    if (push) mem[wr_ptr] <= push_byte;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  assign ev_valid = !empty;
  assign ev_data  = empty ? 8'h00 : mem[rd_ptr];
  assign ev_count = count;
  assign irq      = !empty;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Bench for keypad_event_fifo: directed scenarios followed by random key
// activity, compared each cycle against an event-level reference model.
module tb_keypad_event_fifo;

  localparam int D     = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keypad;
  logic        ev_valid;
  logic [7:0]  ev_data;
  logic        ev_pop;
  logic [3:0]  ev_count;
  logic        overflow;
  logic        clr_overflow;
  logic        irq;

  int tests = 0;
  int fails = 0;

  keypad_event_fifo #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH),
    .ADDR_W         (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keypad      (keypad),
    .ev_valid    (ev_valid),
    .ev_data     (ev_data),
    .ev_pop      (ev_pop),
    .ev_count    (ev_count),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Reference model state: input pipeline, run length of identical samples,
  // accepted key, pending swap press and the event queue itself.
  logic [7:0]  q[$];
  logic        m_ovf;
  logic [15:0] m_stable;
  logic        m_swap;
  logic [3:0]  m_pend;
  logic [15:0] m_s1;
  logic [15:0] m_s;
  logic [15:0] m_prev;
  int          m_run;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] idx_of(input logic [15:0] v);
    return 4'($clog2(v));
  endfunction

  task automatic model_edge();
    logic [15:0] sv;
    logic        have;
    logic [7:0]  ev;
    logic        pop_m;
    logic        acc;
    int          sz;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0; m_stable = '0; m_swap = 1'b0; m_pend = '0;
      m_s1 = '0; m_s = '0; m_prev = '0; m_run = 1;
    end else begin
      sv   = m_s;
      have = 1'b0;
      ev   = 8'h00;
      if (sv == m_prev) m_run++;
      else begin
        m_run  = 1;
        m_prev = sv;
      end
      if (m_swap) begin
        have   = 1'b1;
        ev     = {4'h8, m_pend};
        m_swap = 1'b0;
      end else if (m_run >= D + 1 && $countones(sv) <= 1 && sv != m_stable) begin
        have = 1'b1;
        if (m_stable == 16'd0) ev = {4'h8, idx_of(sv)};
        else begin
          ev = {4'h0, idx_of(m_stable)};
          if (sv != 16'd0) begin
            m_swap = 1'b1;
            m_pend = idx_of(sv);
          end
        end
        m_stable = sv;
      end
      sz    = q.size();
      pop_m = ev_pop && (sz > 0);
      acc   = have && (sz < DEPTH || pop_m);
      if (have && !acc) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      if (pop_m) void'(q.pop_front());
      if (acc) q.push_back(ev);
      m_s  = m_s1;
      m_s1 = keypad;
    end
  endtask

  // One clock: update the model on the edge, compare all outputs 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("valid",    16'(ev_valid), 16'(q.size() > 0));
    check("data",     16'(ev_data),  (q.size() > 0) ? 16'(q[0]) : 16'h0);
    check("count",    16'(ev_count), 16'(q.size()));
    check("overflow", 16'(overflow), 16'(m_ovf));
    check("irq",      16'(irq),      16'(q.size() > 0));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pop_one();
    ev_pop = 1'b1;
    cycle();
    ev_pop = 1'b0;
  endtask

  task automatic tap(input int k);
    keypad = 16'h1 << k;
    cycles(8);
    keypad = 16'h0;
    cycles(8);
  endtask

  initial begin
    int k;
    int r;
    int hold;
    rst = 1'b1; keypad = '0; ev_pop = 1'b0; clr_overflow = 1'b0;

    // 1: reset, single tap of key 5 with exact acceptance latency.
    cycles(2);
    check("rst_valid", 16'(ev_valid), 16'h0);
    check("rst_count", 16'(ev_count), 16'h0);
    check("rst_ovf",   16'(overflow), 16'h0);
    rst = 1'b0;
    keypad = 16'h0020;
    cycles(6);
    check("t1_not_yet", 16'(ev_valid), 16'h0);
    cycle();
    check("t1_valid_e7", 16'(ev_valid), 16'h1);
    check("t1_press",    16'(ev_data),  16'h85);
    cycles(13);
    keypad = 16'h0;
    cycles(10);
    check("t1_count2", 16'(ev_count), 16'h2);
    check("t1_irq",    16'(irq),      16'h1);
    pop_one();
    check("t1_release", 16'(ev_data), 16'h05);
    pop_one();
    check("t1_empty", 16'(ev_valid), 16'h0);

    // 2: glitch shorter than the debounce window.
    keypad = 16'h0020;
    cycles(3);
    keypad = 16'h0;
    cycles(12);
    check("t2_no_event", 16'(ev_valid), 16'h0);

    // 3: direct swap from key 5 to key 8.
    keypad = 16'h0020;
    cycles(10);
    check("t3_count1", 16'(ev_count), 16'h1);
    keypad = 16'h0100;
    cycles(6);
    check("t3_pre", 16'(ev_count), 16'h1);
    cycle();
    check("t3_count2", 16'(ev_count), 16'h2);
    cycle();
    check("t3_count3", 16'(ev_count), 16'h3);
    check("t3_head", 16'(ev_data), 16'h85);
    pop_one();
    check("t3_rel5", 16'(ev_data), 16'h05);
    pop_one();
    check("t3_press8", 16'(ev_data), 16'h88);
    pop_one();
    keypad = 16'h0;
    cycles(10);
    check("t3_rel8", 16'(ev_data), 16'h08);
    pop_one();

    // 4: two-key chord is never accepted.
    keypad = 16'h0021;
    cycles(20);
    check("t4_chord", 16'(ev_valid), 16'h0);
    keypad = 16'h0;
    cycles(10);
    check("t4_after", 16'(ev_valid), 16'h0);

    // 5: nine events without pops, then drain in order.
    for (int i = 0; i < 4; i++) tap($urandom_range(0, 15));
    keypad = 16'h1 << $urandom_range(0, 15);
    cycles(8);
    check("t5_full", 16'(ev_count), 16'h8);
    check("t5_ovf",  16'(overflow), 16'h1);
    ev_pop = 1'b1;
    cycles(8);
    ev_pop = 1'b0;
    check("t5_drained", 16'(ev_valid), 16'h0);
    pop_one();
    check("t5_pop_empty", 16'(ev_count), 16'h0);
    clr_overflow = 1'b1;
    cycle();
    clr_overflow = 1'b0;
    check("t5_clr", 16'(overflow), 16'h0);

    // 6: full FIFO with push and pop on the same edge, then reset mid-debounce.
    keypad = 16'h0;
    cycles(8);
    for (int i = 0; i < 3; i++) tap($urandom_range(0, 15));
    keypad = 16'h1 << $urandom_range(0, 15);
    cycles(8);
    check("t6_full", 16'(ev_count), 16'h8);
    keypad = 16'h0;
    cycles(6);
    ev_pop = 1'b1;
    cycle();
    ev_pop = 1'b0;
    check("t6_count", 16'(ev_count), 16'h8);
    check("t6_no_ovf", 16'(overflow), 16'h0);
    keypad = 16'h0400;
    cycles(3);
    rst = 1'b1;
    keypad = 16'h0;
    cycle();
    check("t6_rst_valid", 16'(ev_valid), 16'h0);
    check("t6_rst_data",  16'(ev_data),  16'h0);
    check("t6_rst_count", 16'(ev_count), 16'h0);
    check("t6_rst_irq",   16'(irq),      16'h0);
    rst = 1'b0;
    cycles(15);
    check("t6_no_event", 16'(ev_valid), 16'h0);

    // Random key activity, pops, clears and occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) keypad = 16'h0;
      else if (r <= 8) keypad = 16'h1 << $urandom_range(0, 15);
      else begin
        k = $urandom_range(0, 15);
        keypad = (16'h1 << k) | (16'h1 << $urandom_range(0, 15));
      end
      hold = $urandom_range(1, 10);
      for (int c = 0; c < hold; c++) begin
        ev_pop       = ($urandom_range(0, 3) == 0);
        clr_overflow = ($urandom_range(0, 15) == 0);
        rst          = ($urandom_range(0, 199) == 0);
        cycle();
      end
    end
    rst = 1'b0; ev_pop = 1'b0; clr_overflow = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_event_fifo.md
Name: keypad_event_fifo

Overview:
- Consumes the 16-bit one-hot `keypad` vector from the matrix keypad scanner.
- Re-times and debounces that vector in the system clock domain, then turns stable changes into press and release events.
- Buffers the events in a small first-word-fall-through (FWFT) FIFO, so the GPIO/MMIO register block can read them at its own pace.
- Exposes a non-empty interrupt line and a sticky overflow flag.

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive identical samples required before a new keypad value is accepted; minimum 2.
- FIFO_DEPTH, 8: number of event entries; must be a power of two.
- ADDR_W, 3: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- keypad  in  16  key vector from the scanner; bit k set means key k is held; expected to be one-hot or zero.
- ev_valid  out  1  FIFO non-empty; ev_data is valid.
- ev_data  out  8  head event: bit7 = 1 press / 0 release, bits6:4 = 0, bits3:0 = key index.
- ev_pop  in  1  consume the head event on this cycle.
- ev_count  out  ADDR_W+1  number of entries currently in the FIFO.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- clr_overflow  in  1  clears overflow.
- irq  out  1  equals ev_valid.

Behaviour:
- Reset (synchronous, rst=1 at a rising clk edge):
  - sync flops, candidate, stable value, debounce counter and FSM cleared.
  - FIFO emptied.
  - All outputs 0: ev_valid, ev_data, ev_count, overflow, irq.
  - Reset asserted mid-debounce or mid-SWAP discards all pending work, with no event emitted.
- Input synchroniser: keypad passes through two flops (sync1, then sync2 = s).
- Debounce, evaluated at every edge:
  - If s != cand: cand <= s, cnt <= 0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Else (cnt == DEBOUNCE_CYCLES-1, saturated): the value is accepted, provided cand is zero or one-hot and cand != stable.
  - A non-one-hot cand (2 or more bits set) is never accepted; stable holds its value and no event is produced.
  - A glitch shorter than DEBOUNCE_CYCLES samples produces nothing.
- FSM:
  - IDLE (stable=0): on acceptance of one-hot k, push press(k) = {1,000,k}, stable <= cand, go to HELD.
  - HELD (stable = one-hot j):
    - Acceptance of 0: push release(j) = {0,000,j}, stable <= 0, go to IDLE.
    - Acceptance of one-hot k != j: push release(j), latch pend <= k, stable <= cand, go to SWAP.
  - SWAP: next cycle push press(pend), go to HELD. Acceptance is suppressed while in SWAP; cnt stays saturated, so a still-different cand is accepted the following cycle.
  - Key index = position of the set bit (0..15).
- Latency:
  - The push happens on the acceptance edge.
  - ev_valid rises after the (DEBOUNCE_CYCLES+3)-th rising edge, counting the first edge after keypad changes as edge 1.
  - For a swap, the press event is pushed exactly one cycle after the release event.
- FIFO:
  - FWFT; ev_data shows the head entry whenever ev_valid=1 and is 0 when empty.
  - Pop happens when ev_pop && ev_valid; ev_pop while empty is ignored with no state change.
  - Push when not full: write at wr_ptr, increment. Pointers wrap modulo FIFO_DEPTH.
  - Push when full and no pop: event dropped, overflow <= 1, contents unchanged.
  - Push and pop in the same cycle, any fill level including full: both occur and ev_count is unchanged. Push-with-pop while full is accepted, so no overflow.
  - A swap's two events occupy two entries; each is accepted or dropped independently.
- Overflow:
  - Cleared by clr_overflow.
  - If a drop and clr_overflow occur in the same cycle, set wins: overflow = 1.
- ev_count range is 0..FIFO_DEPTH; ev_count=FIFO_DEPTH means full.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=8):
1. rst=1 for 2 cycles, keypad=0x0020 held 20 cycles then 0 -> ev_valid=1 after edge 7 with ev_data=0x85; later a second entry 0x05; ev_count=2; irq=1.
2. keypad 0x0020 held 3 cycles then 0 -> no event ever; ev_valid stays 0.
3. Settle 0x0020 (event 0x85), switch directly to 0x0100 -> events 0x05 then 0x88 pushed on consecutive cycles; ev_count goes 1, 2, 3.
4. keypad=0x0021 held 20 cycles -> no event, stable unchanged; then 0x0000 -> still no event.
5. Generate 9 events with no pops -> ev_count=8, overflow=1, 9th dropped. Then pop 8 times -> events out in push order, ev_valid=0 afterwards. Pop on empty -> ev_count stays 0. clr_overflow -> overflow=0.
6. FIFO full, push and pop in the same cycle -> ev_count stays 8, overflow stays 0. Then assert rst mid-debounce of a new key -> all outputs 0 next cycle, no event after release of rst.
